// File: rtl/bcd_pkg.sv
// Shared constants and the active-low 7-segment decoder for the BCD up/down display.
package bcd_pkg;

  localparam int         BCD_W     = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit; non-decimal codes show nothing.
  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, increments on carry-in, decrements on borrow-in.
// cout/bout are combinational so a whole chain ripples within one cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  input  logic             inc,
  input  logic             dec,
  input  logic             cin,
  input  logic             bin,
  output logic [BCD_W-1:0] q,
  output logic             cout,
  output logic             bout
);

  assign cout = cin && (q == BCD_MAX);
  assign bout = bin && (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      // Non-decimal load digits are forced to zero so the chain never holds junk.
      q <= (load_d > BCD_MAX) ? '0 : load_d;
    end else if (inc && cin) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end else if (dec && bin) begin
      q <= (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with count prescaler, parallel load, wrap pulse
// and a multiplexed active-low 7-segment driver with leading-zero blanking.
module bcd_updown_display
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 6000,
  parameter int BLANK_LZ = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] value,
  output logic                    carry,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0] presc;
  logic          tick;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    end
  end

  assign tick = en && (presc == PRESC_MAX);

  // Decade chain: digit 0 always sees carry/borrow-in; the top digit's
  // carry/borrow-out marks a full wrap of the count.
  logic [DIGITS:0] c_chain;
  logic [DIGITS:0] b_chain;

  assign c_chain[0] = 1'b1;
  assign b_chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .load_d (load_val[g*BCD_W +: BCD_W]),
      .inc    (tick && up),
      .dec    (tick && !up),
      .cin    (c_chain[g]),
      .bin    (b_chain[g]),
      .q      (value[g*BCD_W +: BCD_W]),
      .cout   (c_chain[g+1]),
      .bout   (b_chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
    end else begin
      carry <= !load && tick && (up ? c_chain[DIGITS] : b_chain[DIGITS]);
    end
  end

  logic [SW-1:0]    scan_cnt;
  logic [IW-1:0]    idx;
  logic             scan_step;
  logic [BCD_W-1:0] cur_d;
  logic             upper_zero;
  logic             blank;

  assign scan_step = (scan_cnt == SCAN_MAX);

  // Walk from the top digit down so upper_zero covers digits idx..DIGITS-1
  // at the moment the selected digit is reached.
  always_comb begin
    cur_d      = '0;
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (value[i*BCD_W +: BCD_W] != '0) upper_zero = 1'b0;
      if (IW'(i) == idx) begin
        cur_d = value[i*BCD_W +: BCD_W];
        blank = (BLANK_LZ != 0) && (i > 0) && upper_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= SEG_BLANK;
      an       <= '1;
    end else if (scan_step) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      an       <= ~(DIGITS'(1) << idx);
      seg      <= blank ? SEG_BLANK : seg_decode(cur_d);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_updown_display.sv
// Bench for bcd_updown_display: integer-arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_bcd_updown_display;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;
  localparam int BLANK_LZ = 1;
  localparam int MAXV     = 999;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic              up = 1'b1;
  logic              load = 1'b0;
  logic [4*DIGITS-1:0] load_val = '0;
  logic [4*DIGITS-1:0] value;
  logic              carry;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  int checks = 0;
  int errors = 0;

  bcd_updown_display #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .value    (value),
    .carry    (carry),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int pow10 [4] = '{1, 10, 100, 1000};

  int                m_val, m_presc, m_scnt, m_idx;
  logic              m_carry;
  logic [6:0]        m_seg;
  logic [DIGITS-1:0] m_an;
  bit                m_valid = 0;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'((n / pow10[i]) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [4*DIGITS-1:0] lv);
    int n;
    int d;
    n = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 0;
      n += d * pow10[i];
    end
    return n;
  endfunction

  task automatic model_step();
    int d;
    if (reset) begin
      m_val = 0; m_presc = 0; m_scnt = 0; m_idx = 0;
      m_carry = 1'b0; m_seg = 7'h7F; m_an = '1;
      m_valid = 1;
      return;
    end
    // Display samples the count as it stood before this edge.
    if (m_scnt == SCAN_DIV - 1) begin
      m_scnt = 0;
      d = (m_val / pow10[m_idx]) % 10;
      m_an = '1;
      m_an[m_idx] = 1'b0;
      if (BLANK_LZ != 0 && m_idx > 0 && (m_val / pow10[m_idx]) == 0) m_seg = 7'h7F;
      else m_seg = seg_tbl[d];
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_scnt++;
    end
    m_carry = 1'b0;
    if (load) begin
      m_val = from_load(load_val);
      m_presc = 0;
    end else if (en) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        if (up) begin
          m_carry = (m_val == MAXV);
          m_val = (m_val + 1) % (MAXV + 1);
        end else begin
          m_carry = (m_val == 0);
          m_val = (m_val == 0) ? MAXV : m_val - 1;
        end
      end else begin
        m_presc++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model value", 32'(value), 32'(to_bcd(m_val)));
      chk("model carry", 32'(carry), 32'(m_carry));
      chk("model seg",   32'(seg),   32'(m_seg));
      chk("model an",    32'(an),    32'(m_an));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_onset(input logic [DIGITS-1:0] target, input string nm);
    logic [DIGITS-1:0] prev;
    bit found;
    prev = an;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (an == target && prev != target) begin
        found = 1;
        break;
      end
      prev = an;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [2:0] exp_an;
    logic [6:0] exp_seg;

    cyc(2);
    reset = 1'b0;
    chk("reset value", 32'(value), 32'h000);
    chk("reset carry", 32'(carry), 32'd0);
    chk("reset seg",   32'(seg),   32'h7F);
    chk("reset an",    32'(an),    32'b111);
    cyc(1); chk("an idle 1", 32'(an), 32'b111);
    cyc(1); chk("an idle 2", 32'(an), 32'b111);
    cyc(1);
    chk("first scan an",  32'(an),  32'b110);
    chk("first scan seg", 32'(seg), 32'h40);

    // Up-count wrap through 999.
    en = 1'b1; up = 1'b1;
    do_load(12'h998);
    chk("load 998", 32'(value), 32'h998);
    cyc(4);
    chk("up to 999", 32'(value), 32'h999);
    chk("no carry at 999", 32'(carry), 32'd0);
    cyc(4);
    chk("wrap to 000", 32'(value), 32'h000);
    chk("up carry", 32'(carry), 32'd1);
    cyc(1);
    chk("up carry one cycle", 32'(carry), 32'd0);

    // Down-count wrap through 000, then freeze mid-prescale.
    up = 1'b0;
    do_load(12'h000);
    cyc(4);
    chk("down wrap 999", 32'(value), 32'h999);
    chk("down carry", 32'(carry), 32'd1);
    cyc(1);
    chk("down carry one cycle", 32'(carry), 32'd0);
    en = 1'b0;
    cyc(10);
    chk("hold while en=0", 32'(value), 32'h999);
    en = 1'b1;
    cyc(2);
    chk("resume no early tick", 32'(value), 32'h999);
    cyc(1);
    chk("resume tick", 32'(value), 32'h998);

    // Invalid digit sanitised; load beats a simultaneous tick.
    up = 1'b1;
    do_load(12'h1A5);
    chk("load sanitised", 32'(value), 32'h105);
    cyc(3);
    chk("pre-collision", 32'(value), 32'h105);
    do_load(12'h321);
    chk("load wins over tick", 32'(value), 32'h321);
    chk("no carry on load", 32'(carry), 32'd0);

    // Display of 007: digit0 shows 7, upper digits blanked.
    en = 1'b0;
    do_load(12'h007);
    wait_onset(3'b110, "onset 007");
    for (int k = 0; k < 9; k++) begin
      exp_an  = (k < 3) ? 3'b110 : (k < 6) ? 3'b101 : 3'b011;
      exp_seg = (k < 3) ? 7'h78 : 7'h7F;
      chk("scan 007 an",  32'(an),  32'(exp_an));
      chk("scan 007 seg", 32'(seg), 32'(exp_seg));
      cyc(1);
    end

    // Display of 070: inner zero digit0 is shown, not blanked.
    do_load(12'h070);
    wait_onset(3'b101, "onset 070 d1");
    chk("070 digit1 seg", 32'(seg), 32'h78);
    wait_onset(3'b011, "onset 070 d2");
    chk("070 digit2 blank", 32'(seg), 32'h7F);
    wait_onset(3'b110, "onset 070 d0");
    chk("070 digit0 seg", 32'(seg), 32'h40);

    // Reset mid-count and mid-scan.
    en = 1'b1; up = 1'b1;
    cyc(6);
    reset = 1'b1;
    cyc(1);
    chk("mid reset value", 32'(value), 32'h000);
    chk("mid reset carry", 32'(carry), 32'd0);
    chk("mid reset seg",   32'(seg),   32'h7F);
    chk("mid reset an",    32'(an),    32'b111);
    reset = 1'b0;
    cyc(3);
    chk("presc restart hold", 32'(value), 32'h000);
    cyc(1);
    chk("presc restart tick", 32'(value), 32'h001);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
